iter_right_shifter: RTL and testbench



---
 rtl/iter_right_shifter.sv | 120 ++++++++++++
 tb/tb_iter_right_shifter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/iter_right_shifter.sv
// iter_right_shifter: multi-cycle right shifter (logical/arithmetic) with a
// start/done handshake. The result appears on out_data only on completion.
// Optional build macro ITER_SHIFT_FAST_EN: shift two bits per edge while
// at least two remain, otherwise one; results are unchanged, latency halves.
module iter_right_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               fill_q, fill_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] count_next;
  logic               last_step;

  // One shift step of the work register and whether it finishes the operation
  always_comb begin
    shifted    = {fill_q, work_q[WIDTH-1:1]};
    count_next = count_q - SHAMT_W'(1);
    last_step  = (count_q == SHAMT_W'(1));
`ifdef ITER_SHIFT_FAST_EN
    if (count_q >= SHAMT_W'(2)) begin
      shifted    = {{2{fill_q}}, work_q[WIDTH-1:2]};
      count_next = count_q - SHAMT_W'(2);
      last_step  = (count_q == SHAMT_W'(2));
    end
`endif
  end

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    count_d = count_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = in_data;
          count_d = shamt;
          fill_d  = arith & in_data[WIDTH-1];
          if (shamt == '0) begin
            // Zero shift completes straight away with the operand itself
            out_d   = in_data;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = shifted;
        count_d = count_next;
        if (last_step) begin
          out_d   = shifted;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_iter_right_shifter.sv
// tb_iter_right_shifter: directed and random checks of iter_right_shifter
// against a plain-arithmetic reference model. Honors ITER_SHIFT_FAST_EN.
module tb_iter_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] out_data;

  int          n_cmp;
  int          n_err;
  logic [31:0] prev_out;

  iter_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .shamt    (shamt),
    .arith    (arith),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Reference: logical shift is division by 2**n; arithmetic on a negative
  // value is the complement of the logically shifted complement.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n,
                                            input logic a);
    logic [31:0] q;
    q = d / (32'd1 << n);
    if (a && d[31]) q = ~((~d) / (32'd1 << n));
    return q;
  endfunction

  function automatic int ref_latency(input int n);
`ifdef ITER_SHIFT_FAST_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation; optionally holds start high with junk during busy
  task automatic do_op(input string tag, input logic [31:0] d, input int n,
                       input logic a, input logic inject);
    logic [31:0] exp;
    int          lat;
    exp = ref_shift(d, n, a);
    lat = ref_latency(n);
    @(negedge clk);
    start   = 1'b1;
    in_data = d;
    shamt   = 5'(n);
    arith   = a;
    @(posedge clk); #1;
    start   = inject;
    in_data = inject ? 32'd2 : $urandom;
    shamt   = 5'($urandom);
    arith   = 1'($urandom);
    for (int j = 0; j <= lat; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      check({tag, " done"}, 32'(done), 32'(j == lat));
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " out"}, out_data, (j == lat) ? exp : prev_out);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " held out"}, out_data, exp);
    prev_out = exp;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    shamt    = 5'd3;
    arith    = 1'b1;
    n_cmp    = 0;
    n_err    = 0;
    prev_out = '0;

    // Reset held with clock running and start asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst out", out_data, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst out", out_data, 32'd0);

    // Directed cases
    do_op("lsr56", 32'd56, 2, 1'b0, 1'b0);
    do_op("asr_neg", 32'h8000_0000, 4, 1'b1, 1'b0);
    do_op("lsr_neg", 32'h8000_0000, 4, 1'b0, 1'b0);
    do_op("asr_ones31", 32'hFFFF_FFFF, 31, 1'b1, 1'b0);
    do_op("zero", 32'd12, 0, 1'b0, 1'b0);
    do_op("lsr31", 32'hFFFF_FFFF, 31, 1'b0, 1'b0);
    do_op("asr_pos", 32'h7000_0000, 3, 1'b1, 1'b0);
    do_op("fast40", 32'h40, 5, 1'b0, 1'b0);
    do_op("ignore_start", 32'hF0F0_0000, 6, 1'b1, 1'b1);
    do_op("zero_inject", 32'hA5A5_A5A5, 0, 1'b1, 1'b1);
    do_op("one", 32'h8000_0001, 1, 1'b1, 1'b0);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    start   = 1'b1;
    in_data = 32'h1234_5678;
    shamt   = 5'd10;
    arith   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort out", out_data, 32'd0);
    check("abort done", 32'(done), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("abort no done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    prev_out = '0;

    // Randomized operations
    for (int r = 0; r < 30; r++) begin
      do_op("rand", $urandom, int'($urandom_range(0, 31)), 1'($urandom),
            1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
